mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer for the shared single-port `memory` instance. It lets the hart (port 0) and a second requester (port 1, e.g. program loader or debug port) share the memory. It enforces the fixed read latency by holding the address stable and returning data with a valid strobe. Round-robin arbitration; writes complete in one cycle, reads occupy the memory for READ_LATENCY+1 cycles.

## Interface
- READ_LATENCY, 2, cycles after the accept cycle until `mem_rdata` is valid; legal 1..3
- XLEN, from `isa_types`, data/address width
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- p0_req, p1_req  in  1  request; held with its payload until granted
- p0_wenable, p1_wenable  in  1  1 = write, 0 = read
- p0_addr, p1_addr  in  XLEN  byte address
- p0_wwidth, p1_wwidth  in  write_width_t  write width (write_byte/halfword/word)
- p0_wdata, p1_wdata  in  XLEN  write data
- p0_gnt, p1_gnt  out  1  single-cycle accept strobe (combinational)
- p0_rvalid, p1_rvalid  out  1  single-cycle read-data-valid strobe
- rdata  out  XLEN  read data, meaningful only while a `pN_rvalid` is high
- mem_addr  out  XLEN  to memory
- mem_wwidth  out  write_width_t  to memory
- mem_wenable  out  1  to memory
- mem_wdata  out  XLEN  to memory
- mem_rdata  in  XLEN  from memory

## Operation
- States: IDLE, READ. Registers: `state`, `owner` (read port), `addr_q`, `cnt` (2 bits), `last_gnt` (1 bit).
- IDLE arbitration:
  - If only one port has `req`, that port wins.
  - If both ports have `req`, the port != `last_gnt` wins.
  - The winner's `gnt` is high this cycle, and `last_gnt` <= winner.
- IDLE, winner write:
  - Drive `mem_addr`/`mem_wdata`/`mem_wwidth` from the winner and set `mem_wenable`=1.
  - The write commits at this edge. Stay in IDLE.
  - The next request can be granted the following cycle.
- IDLE, winner read:
  - Drive `mem_addr` = winner addr, `mem_wenable`=0.
  - Latch `addr_q`, set `owner`, `cnt` <= READ_LATENCY, go to READ.
- READ:
  - `mem_addr` = `addr_q`, `mem_wenable`=0.
  - If `cnt`==1: `p<owner>_rvalid`=1, `rdata`=`mem_rdata`, go to IDLE.
  - Otherwise `cnt` <= `cnt`-1.
  - No grants are issued in READ; requests wait.
- Idle bus values (no grant, or in READ): `mem_wenable`=0, `mem_wdata`=0, `mem_wwidth`=write_byte. With no activity, `mem_addr`=0.
- After its grant, a requester may drop or change `req` and the payload. `addr_q` isolates the in-flight read.
- `rdata` = `mem_rdata` at all times. Consumers qualify it with `rvalid`.

## Timing
- Reset (sampled at the edge):
  - Resulting state: `state`=IDLE, `cnt`=0, `last_gnt`=1, so port 0 wins the first tie.
  - While `reset` is high: both `gnt`=0, both `rvalid`=0, `mem_wenable`=0, and requests are ignored.
- Reset during READ aborts the read: no `rvalid` is ever produced for it.
- Write latency: `gnt` and the write happen in the same cycle. Throughput is 1 write/cycle; with both ports requesting, grants alternate each cycle.
- Read latency:
  - Accept cycle T (gnt); `rvalid` in cycle T+READ_LATENCY.
  - The address is held READ_LATENCY+1 cycles.
  - The earliest next grant is T+READ_LATENCY+1.
- `gnt` and `rvalid` are never asserted in the same cycle, and never for both ports at once.
- `gnt` never asserts without the matching `req` high in the same cycle.

## Test plan
- Reset, then p0 read of addr 0x10 alone (READ_LATENCY=2):
  - p0_gnt in cycle 0; `mem_addr`=0x10 in cycles 0-2.
  - p0_rvalid only in cycle 2, `rdata` = word at 0x10.
  - p1_gnt and p1_rvalid stay 0 throughout.
- Both ports request writes every cycle (p0 to 0x20 = 0xAAAA_AAAA word, p1 to 0x24 = 0x5555_5555 word):
  - Grants alternate p0, p1, p0, ..., with p0 first after reset.
  - Memory readback matches.
- p0 read granted; p1 write request arrives in cycle 1:
  - p1_gnt is withheld until cycle 3.
  - The write lands with `mem_wenable` high only in cycle 3.
- p1 sb of 0xFF to 0x31 over a pre-written word 0x1122_3344 at 0x30:
  - `mem_wwidth`=write_byte during the grant.
  - Readback of 0x30 is 0x1122_FF44.
- Reset asserted in the second cycle of a p0 read:
  - No p0_rvalid.
  - After reset, `last_gnt`=1 and a simultaneous p0/p1 request grants p0.
- READ_LATENCY=1 build: a read returns `rvalid` one cycle after `gnt`, and the next grant is possible 2 cycles after the first `gnt`.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Shared ISA types plus the arbiter bundle: two requester ports and the memory side.
// The slave modport is the arbiter's view; the master modport is the requesters' and memory's view.
package isa_types;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {
    write_byte     = 2'd0,
    write_halfword = 2'd1,
    write_word     = 2'd2
  } write_width_t;
endpackage

interface mem_arbiter_if;
  import isa_types::*;

  logic            p0_req;
  logic            p1_req;
  logic            p0_wenable;
  logic            p1_wenable;
  logic [XLEN-1:0] p0_addr;
  logic [XLEN-1:0] p1_addr;
  write_width_t    p0_wwidth;
  write_width_t    p1_wwidth;
  logic [XLEN-1:0] p0_wdata;
  logic [XLEN-1:0] p1_wdata;
  logic            p0_gnt;
  logic            p1_gnt;
  logic            p0_rvalid;
  logic            p1_rvalid;
  logic [XLEN-1:0] rdata;
  logic [XLEN-1:0] mem_addr;
  write_width_t    mem_wwidth;
  logic            mem_wenable;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  p0_req, p1_req, p0_wenable, p1_wenable,
    input  p0_addr, p1_addr, p0_wwidth, p1_wwidth,
    input  p0_wdata, p1_wdata, mem_rdata,
    output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid,
    output rdata, mem_addr, mem_wwidth, mem_wenable,
    output mem_wdata
  );

  modport master (
    output p0_req, p1_req, p0_wenable, p1_wenable,
    output p0_addr, p1_addr, p0_wwidth, p1_wwidth,
    output p0_wdata, p1_wdata, mem_rdata,
    input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid,
    input  rdata, mem_addr, mem_wwidth, mem_wenable,
    input  mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter for the single-port memory.
// Writes finish in the grant cycle; reads hold the address until rdata is strobed.
module mem_arbiter
  import isa_types::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, READ} state_t;

  localparam logic [1:0] CntInit = 2'(READ_LATENCY);

  state_t          state_q;
  logic            owner_q;
  logic [XLEN-1:0] addr_q;
  logic [1:0]      cnt_q;
  logic            last_gnt_q;

  logic            pick1;
  logic            acc;
  logic            rv;
  logic            win_we;
  logic [XLEN-1:0] win_addr;
  logic [XLEN-1:0] win_wdata;
  write_width_t    win_wwidth;

  always_comb begin
    // on a tie the port that did not win last time goes first
    pick1 = bus.p1_req & (~bus.p0_req | ~last_gnt_q);
    acc   = ~reset & (state_q == IDLE)
          & (bus.p0_req | bus.p1_req);
    unique case (1'b1)
      pick1: begin
        win_we     = bus.p1_wenable;
        win_addr   = bus.p1_addr;
        win_wdata  = bus.p1_wdata;
        win_wwidth = bus.p1_wwidth;
      end
      default: begin
        win_we     = bus.p0_wenable;
        win_addr   = bus.p0_addr;
        win_wdata  = bus.p0_wdata;
        win_wwidth = bus.p0_wwidth;
      end
    endcase

    bus.p0_gnt = acc & ~pick1;
    bus.p1_gnt = acc & pick1;

    rv = ~reset & (state_q == READ) & (cnt_q == 2'd1);
    bus.p0_rvalid = rv & ~owner_q;
    bus.p1_rvalid = rv & owner_q;
    bus.rdata     = bus.mem_rdata;

    bus.mem_wenable = acc & win_we;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.mem_wwidth  = write_byte;
    if (state_q == READ) begin
      bus.mem_addr = addr_q;
    end else if (acc) begin
      bus.mem_addr = win_addr;
      if (win_we) begin
        bus.mem_wdata  = win_wdata;
        bus.mem_wwidth = win_wwidth;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= 2'd0;
      last_gnt_q <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (acc) begin
            last_gnt_q <= pick1;
            if (!win_we) begin
              addr_q  <= win_addr;
              owner_q <= pick1;
              cnt_q   <= CntInit;
              state_q <= READ;
            end
          end
        end
        READ: begin
          if (cnt_q == 2'd1) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte memory model, vector table, corner sequences,
// and a random run against a transaction-level arbitration model.
module tb_mem_arbiter;
  import isa_types::*;

  localparam int RL = 2;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();
  mem_arbiter_if bus1 ();

  mem_arbiter #(.READ_LATENCY(RL)) dut (
    .clock(clk), .reset(rst), .bus(bus.slave)
  );
  mem_arbiter #(.READ_LATENCY(1)) dut1 (
    .clock(clk), .reset(rst), .bus(bus1.slave)
  );

  logic [7:0]  mem [0:255];
  logic [7:0]  ref_mem [0:255];
  logic [31:0] r1, r2, r1b;
  logic [7:0]  wa;
  logic [31:0] wd;
  assign wa = bus.mem_addr[7:0];
  assign wd = bus.mem_wdata;

  function automatic logic [31:0] mword(input logic [7:0] a);
    return {mem[{a[7:2], 2'd3}], mem[{a[7:2], 2'd2}],
            mem[{a[7:2], 2'd1}], mem[{a[7:2], 2'd0}]};
  endfunction

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
    end else if (bus.mem_wenable) begin
      case (bus.mem_wwidth)
        write_byte: mem[wa] <= wd[7:0];
        write_halfword: begin
          mem[{wa[7:1], 1'b0}] <= wd[7:0];
          mem[{wa[7:1], 1'b1}] <= wd[15:8];
        end
        default: begin
          mem[{wa[7:2], 2'd0}] <= wd[7:0];
          mem[{wa[7:2], 2'd1}] <= wd[15:8];
          mem[{wa[7:2], 2'd2}] <= wd[23:16];
          mem[{wa[7:2], 2'd3}] <= wd[31:24];
        end
      endcase
    end
    r1  <= mword(wa);
    r2  <= r1;
    r1b <= bus1.mem_addr ^ 32'hC0DE_0000;
  end
  assign bus.mem_rdata  = r2;
  assign bus1.mem_rdata = r1b;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic setp(int p, logic r, logic we, logic [31:0] a,
                      logic [31:0] d, write_width_t w);
    if (p == 0) begin
      bus.p0_req = r; bus.p0_wenable = we; bus.p0_addr = a;
      bus.p0_wdata = d; bus.p0_wwidth = w;
    end else begin
      bus.p1_req = r; bus.p1_wenable = we; bus.p1_addr = a;
      bus.p1_wdata = d; bus.p1_wwidth = w;
    end
  endtask

  function automatic logic gntp(int p);
    return (p == 0) ? bus.p0_gnt : bus.p1_gnt;
  endfunction

  function automatic logic rvp(int p);
    return (p == 0) ? bus.p0_rvalid : bus.p1_rvalid;
  endfunction

  task automatic wr(int p, logic [31:0] a, logic [31:0] d,
                    write_width_t w, string nm);
    logic ok;
    ok = 1'b0;
    setp(p, 1'b1, 1'b1, a, d, w);
    for (int k = 0; k < 8 && !ok; k++) begin
      @(negedge clk);
      ok = gntp(p);
      nxt();
    end
    setp(p, 1'b0, 1'b0, 32'h0, 32'h0, write_byte);
    chk({nm, "_gnt"}, 32'(ok), 32'd1);
  endtask

  task automatic rd(int p, logic [31:0] a, logic [31:0] exp, string nm);
    logic ok;
    ok = 1'b0;
    setp(p, 1'b1, 1'b0, a, 32'h0, write_byte);
    for (int k = 0; k < 8 && !ok; k++) begin
      @(negedge clk);
      ok = gntp(p);
      nxt();
    end
    setp(p, 1'b0, 1'b0, 32'h0, 32'h0, write_byte);
    chk({nm, "_gnt"}, 32'(ok), 32'd1);
    if (ok) begin
      ok = 1'b0;
      for (int k = 0; k < 8 && !ok; k++) begin
        @(negedge clk);
        if (rvp(p)) begin
          ok = 1'b1;
          chk(nm, bus.rdata, exp);
        end
        nxt();
      end
      chk({nm, "_rv"}, 32'(ok), 32'd1);
    end
  endtask

  task automatic ref_wr(logic [7:0] a, logic [31:0] d, write_width_t w);
    case (w)
      write_byte: ref_mem[a] = d[7:0];
      write_halfword: begin
        ref_mem[{a[7:1], 1'b0}] = d[7:0];
        ref_mem[{a[7:1], 1'b1}] = d[15:8];
      end
      default: begin
        for (int b = 0; b < 4; b++)
          ref_mem[{a[7:2], 2'(b)}] = d[8*b +: 8];
      end
    endcase
  endtask

  function automatic logic [31:0] ref_rd(logic [7:0] a);
    return {ref_mem[{a[7:2], 2'd3}], ref_mem[{a[7:2], 2'd2}],
            ref_mem[{a[7:2], 2'd1}], ref_mem[{a[7:2], 2'd0}]};
  endfunction

  typedef struct packed {
    logic        r0;
    logic        r1;
    logic        g0;
    logic        g1;
    logic [31:0] addr;
    logic        wen;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]   eg, erv, grv;
    logic [31:0]  edata, eaddr;
    logic         ewen;
    int           busy, rp, w;
    logic         last;
    logic [31:0]  rdat;
    logic         pend [2];
    logic         pwe [2];
    logic [31:0]  pad [2];
    logic [31:0]  pdat [2];
    write_width_t pww [2];

    tbl = '{
      '{1'b1, 1'b1, 1'b1, 1'b0, 32'h20, 1'b1},
      '{1'b1, 1'b1, 1'b0, 1'b1, 32'h24, 1'b1},
      '{1'b0, 1'b1, 1'b0, 1'b1, 32'h24, 1'b1},
      '{1'b1, 1'b1, 1'b1, 1'b0, 32'h20, 1'b1},
      '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0},
      '{1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 1'b1},
      '{1'b1, 1'b1, 1'b0, 1'b1, 32'h24, 1'b1}
    };

    // reset with both ports requesting: nothing may be granted
    rst = 1'b1;
    clr = 1'b1;
    setp(0, 1'b1, 1'b1, 32'h20, 32'hAAAA_AAAA, write_word);
    setp(1, 1'b1, 1'b1, 32'h24, 32'h5555_5555, write_word);
    bus1.p0_req = 1'b0; bus1.p0_wenable = 1'b0; bus1.p0_addr = '0;
    bus1.p0_wdata = '0; bus1.p0_wwidth = write_byte;
    bus1.p1_req = 1'b0; bus1.p1_wenable = 1'b0; bus1.p1_addr = '0;
    bus1.p1_wdata = '0; bus1.p1_wwidth = write_byte;
    @(negedge clk);
    chk("rst_gnt", {bus.p0_gnt, bus.p1_gnt}, 2'b00);
    chk("rst_rv", {bus.p0_rvalid, bus.p1_rvalid}, 2'b00);
    chk("rst_wen", 32'(bus.mem_wenable), 32'd0);
    nxt();
    rst = 1'b0;
    clr = 1'b0;

    for (int i = 0; i < 7; i++) begin
      bus.p0_req = tbl[i].r0;
      bus.p1_req = tbl[i].r1;
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt", i), {bus.p0_gnt, bus.p1_gnt},
          {tbl[i].g0, tbl[i].g1});
      chk($sformatf("tbl%0d_addr", i), bus.mem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_wen", i), 32'(bus.mem_wenable),
          32'(tbl[i].wen));
      nxt();
    end
    setp(0, 1'b0, 1'b0, 32'h0, 32'h0, write_byte);
    setp(1, 1'b0, 1'b0, 32'h0, 32'h0, write_byte);

    // lone p0 read of 0x10: address held three cycles, rvalid in the third
    wr(1, 32'h10, 32'hDEAD_BEEF, write_word, "a_pre");
    setp(0, 1'b1, 1'b0, 32'h10, 32'h0, write_byte);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("a_c%0d_gnt", c), {bus.p0_gnt, bus.p1_gnt},
          (c == 0) ? 2'b10 : 2'b00);
      chk($sformatf("a_c%0d_rv", c), {bus.p0_rvalid, bus.p1_rvalid},
          (c == 2) ? 2'b10 : 2'b00);
      if (c < 3) chk($sformatf("a_c%0d_addr", c), bus.mem_addr, 32'h10);
      if (c == 2) chk("a_rdata", bus.rdata, 32'hDEAD_BEEF);
      nxt();
      setp(0, 1'b0, 1'b0, 32'h0, 32'h0, write_byte);
    end

    // p1 write arriving behind a p0 read waits until the read drains
    setp(0, 1'b1, 1'b0, 32'h20, 32'h0, write_byte);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("b_c%0d_gnt", c), {bus.p0_gnt, bus.p1_gnt},
          (c == 0) ? 2'b10 : (c == 3) ? 2'b01 : 2'b00);
      chk($sformatf("b_c%0d_wen", c), 32'(bus.mem_wenable),
          (c == 3) ? 32'd1 : 32'd0);
      if (c == 2) chk("b_rd20", bus.rdata, 32'hAAAA_AAAA);
      nxt();
      setp(0, 1'b0, 1'b0, 32'h0, 32'h0, write_byte);
      if (c == 0) setp(1, 1'b1, 1'b1, 32'h40, 32'h1234_5678, write_word);
      if (c == 3) setp(1, 1'b0, 1'b0, 32'h0, 32'h0, write_byte);
    end
    rd(1, 32'h24, 32'h5555_5555, "b_rd24");
    rd(0, 32'h40, 32'h1234_5678, "b_rd40");

    // byte store into the middle of a word
    wr(0, 32'h30, 32'h1122_3344, write_word, "c_sw");
    setp(1, 1'b1, 1'b1, 32'h31, 32'h0000_00FF, write_byte);
    @(negedge clk);
    chk("c_gnt", 32'(bus.p1_gnt), 32'd1);
    chk("c_wen", 32'(bus.mem_wenable), 32'd1);
    chk("c_width", 32'(bus.mem_wwidth), 32'(write_byte));
    nxt();
    setp(1, 1'b0, 1'b0, 32'h0, 32'h0, write_byte);
    rd(0, 32'h30, 32'h1122_FF44, "c_rd30");

    // reset in the middle of a read drops it; tie afterwards goes to p0
    setp(0, 1'b1, 1'b0, 32'h10, 32'h0, write_byte);
    @(negedge clk);
    chk("d_gnt", 32'(bus.p0_gnt), 32'd1);
    nxt();
    setp(0, 1'b0, 1'b0, 32'h0, 32'h0, write_byte);
    rst = 1'b1;
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("d_c%0d_rv", c), {bus.p0_rvalid, bus.p1_rvalid}, 2'b00);
      nxt();
      rst = 1'b0;
    end
    setp(0, 1'b1, 1'b1, 32'h50, 32'h1, write_word);
    setp(1, 1'b1, 1'b1, 32'h54, 32'h2, write_word);
    @(negedge clk);
    chk("d_tie", {bus.p0_gnt, bus.p1_gnt}, 2'b10);
    nxt();
    setp(0, 1'b0, 1'b0, 32'h0, 32'h0, write_byte);
    setp(1, 1'b0, 1'b0, 32'h0, 32'h0, write_byte);
    nxt();

    // latency-1 instance: rvalid one cycle after gnt, next grant two after
    bus1.p0_req = 1'b1; bus1.p0_addr = 32'h40;
    @(negedge clk);
    chk("e_g0", {bus1.p0_gnt, bus1.p1_gnt}, 2'b10);
    nxt();
    bus1.p0_req = 1'b0;
    bus1.p1_req = 1'b1; bus1.p1_addr = 32'h44;
    @(negedge clk);
    chk("e_rv0", {bus1.p0_rvalid, bus1.p1_rvalid}, 2'b10);
    chk("e_rd0", bus1.rdata, 32'hC0DE_0040);
    chk("e_nog1", 32'(bus1.p1_gnt), 32'd0);
    nxt();
    @(negedge clk);
    chk("e_g1", {bus1.p0_gnt, bus1.p1_gnt}, 2'b01);
    nxt();
    bus1.p1_req = 1'b0;
    @(negedge clk);
    chk("e_rv1", {bus1.p0_rvalid, bus1.p1_rvalid}, 2'b01);
    chk("e_rd1", bus1.rdata, 32'hC0DE_0044);
    nxt();

    // random traffic against a transaction model
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i);
    busy = 0; rp = 0; rdat = '0; last = 1'b1;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int cy = 0; cy < 400; cy++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 1) == 1) begin
          pend[p] = 1'b1;
          pwe[p]  = 1'($urandom_range(0, 1));
          pad[p]  = 32'h80 + 32'($urandom_range(0, 63));
          pdat[p] = $urandom;
          pww[p]  = write_width_t'($urandom_range(0, 2));
        end
        if (pend[p]) setp(p, 1'b1, pwe[p], pad[p], pdat[p], pww[p]);
        else setp(p, 1'b0, 1'b0, 32'h0, 32'h0, write_byte);
      end
      eg = 2'b00; erv = 2'b00; edata = '0; ewen = 1'b0; eaddr = '0;
      w = 0;
      if (busy > 0) begin
        if (busy == 1) begin
          erv[rp] = 1'b1;
          edata = rdat;
        end
        busy--;
      end else if (pend[0] || pend[1]) begin
        w = (pend[0] && pend[1]) ? int'(!last) : (pend[1] ? 1 : 0);
        eg[w] = 1'b1;
        last = 1'(w);
        if (pwe[w]) begin
          ewen = 1'b1;
          eaddr = pad[w];
          ref_wr(pad[w][7:0], pdat[w], pww[w]);
        end else begin
          busy = RL;
          rp = w;
          rdat = ref_rd(pad[w][7:0]);
        end
      end
      @(negedge clk);
      grv = {bus.p1_gnt, bus.p0_gnt};
      chk($sformatf("rnd%0d_gnt", cy), 32'(grv), 32'(eg));
      grv = {bus.p1_rvalid, bus.p0_rvalid};
      chk($sformatf("rnd%0d_rv", cy), 32'(grv), 32'(erv));
      chk($sformatf("rnd%0d_wen", cy), 32'(bus.mem_wenable), 32'(ewen));
      if (erv != 2'b00) chk($sformatf("rnd%0d_rdata", cy), bus.rdata, edata);
      if (ewen) chk($sformatf("rnd%0d_addr", cy), bus.mem_addr, eaddr);
      if (eg != 2'b00) pend[w] = 1'b0;
      nxt();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
